// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg
//   Shared definitions for the serial program loader: the frame sync byte,
//   the loader FSM state encoding, the UART receiver state encoding and a
//   helper that decodes "frame in progress" from the loader state.
//   No ports (package).
package prog_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_RUN
  } load_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  function automatic logic is_busy(input load_state_t s);
    return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if
//   Bundles the loader's serial input and its RAM/cpu-facing outputs.
//   master : the loader (consumes rx, drives RAM write bus and cpu control)
//   slave  : the surroundings (UART source, program RAM, cpu)
//   Signals: rx (UART line, idle high), ram_we (1-cycle write strobe),
//            ram_adr[7:0], ram_wdata[7:0], cpu_reset_n (0 = hold cpu),
//            busy (frame in progress), err (sticky error flag)
interface prog_loader_if;
  logic       rx;
  logic       ram_we;
  logic [7:0] ram_adr;
  logic [7:0] ram_wdata;
  logic       cpu_reset_n;
  logic       busy;
  logic       err;

  modport master (
    input  rx,
    output ram_we, ram_adr, ram_wdata, cpu_reset_n, busy, err
  );

  modport slave (
    output rx,
    input  ram_we, ram_adr, ram_wdata, cpu_reset_n, busy, err
  );
endinterface

// File: rtl/prog_loader_uart_rx_byte.sv
// uart_rx_byte
//   8N1 UART byte receiver, LSB first, CLKS_PER_BIT clocks per bit.
//   Ports: clk, reset (async, active-high), rx (asynchronous serial line),
//          data[7:0] (last received byte), valid (1-cycle pulse after a good
//          stop bit), frame_err (1-cycle pulse when the stop bit reads 0).
module uart_rx_byte
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [2:0]       bit_q, bit_n;
  logic [7:0]       shift_q, shift_n;
  logic             valid_q, valid_n;
  logic             ferr_q, ferr_n;
  logic             rx_s1, rx_s2, rx_prev;

  // Synchronizer and edge-history flops reset low: a line that is already low
  // when reset releases (byte in flight) never looks like a fresh 1->0 edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1   <= 1'b0;
      rx_s2   <= 1'b0;
      rx_prev <= 1'b0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      valid_q <= valid_n;
      ferr_q  <= ferr_n;
    end
  end

  // Start bit is checked half a bit after the edge so that every later sample
  // lands mid-bit; a start bit that has gone high again was a glitch.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q + CNT_W'(1);
    bit_n   = bit_q;
    shift_n = shift_q;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_n = '0;
        if (rx_prev && !rx_s2) state_n = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_n = '0;
          bit_n = '0;
          state_n = rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_CNT) begin
          cnt_n   = '0;
          shift_n = {rx_s2, shift_q[7:1]};
          bit_n   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_CNT) begin
          cnt_n   = '0;
          state_n = RX_IDLE;
          if (rx_s2) valid_n = 1'b1;
          else       ferr_n  = 1'b1;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  assign data      = shift_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;

endmodule

// File: rtl/prog_loader.sv
// prog_loader
//   Receives a framed program over UART (A5, length L, L data bytes, 8-bit
//   sum of data) and writes it into program RAM; the cpu is held in reset
//   while loading and released only after the checksum matches.
//   Ports: clk, reset (async, active-high),
//          bus (prog_loader_if.master): rx in; ram_we, ram_adr, ram_wdata,
//          cpu_reset_n, busy, err out.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int ADDR_W       = 4
) (
  input  logic           clk,
  input  logic           reset,
  prog_loader_if.master  bus
);

  localparam logic [8:0] DEPTH = 9'(2 ** ADDR_W);

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_frame_err;

  load_state_t state_q, state_n;
  logic [8:0]  count_q, count_n;
  logic [8:0]  idx_q, idx_n;
  logic [7:0]  sum_q, sum_n;
  logic        we_q, we_n;
  logic [7:0]  adr_q, adr_n;
  logic [7:0]  wdata_q, wdata_n;
  logic        cpu_q, cpu_n;
  logic        err_q, err_n;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (bus.rx),
    .data      (rx_data),
    .valid     (rx_valid),
    .frame_err (rx_frame_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdata_q <= '0;
      cpu_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      count_q <= count_n;
      idx_q   <= idx_n;
      sum_q   <= sum_n;
      we_q    <= we_n;
      adr_q   <= adr_n;
      wdata_q <= wdata_n;
      cpu_q   <= cpu_n;
      err_q   <= err_n;
    end
  end

  // A framing error aborts any frame but leaves cpu_reset_n alone, so a
  // running cpu keeps running on line noise. IDLE and RUN differ only in
  // the cpu_reset_n value they hold.
  always_comb begin
    state_n = state_q;
    count_n = count_q;
    idx_n   = idx_q;
    sum_n   = sum_q;
    we_n    = 1'b0;
    adr_n   = adr_q;
    wdata_n = wdata_q;
    cpu_n   = cpu_q;
    err_n   = err_q;
    if (rx_frame_err) begin
      err_n   = 1'b1;
      state_n = ST_IDLE;
    end else if (rx_valid) begin
      case (state_q)
        ST_IDLE, ST_RUN: begin
          if (rx_data == SYNC_BYTE) begin
            err_n   = 1'b0;
            cpu_n   = 1'b0;
            state_n = ST_LEN;
          end
        end
        ST_LEN: begin
          if (rx_data != 8'd0 && {1'b0, rx_data} <= DEPTH) begin
            count_n = {1'b0, rx_data};
            idx_n   = '0;
            sum_n   = '0;
            state_n = ST_DATA;
          end else begin
            err_n   = 1'b1;
            state_n = ST_IDLE;
          end
        end
        ST_DATA: begin
          we_n    = 1'b1;
          wdata_n = rx_data;
          adr_n   = '0;
          adr_n[ADDR_W-1:0] = idx_q[ADDR_W-1:0];
          sum_n   = sum_q + rx_data;
          idx_n   = idx_q + 9'd1;
          if (idx_q + 9'd1 == count_q) state_n = ST_CSUM;
        end
        ST_CSUM: begin
          if (rx_data == sum_q) begin
            cpu_n   = 1'b1;
            state_n = ST_RUN;
          end else begin
            err_n   = 1'b1;
            state_n = ST_IDLE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign bus.ram_we      = we_q;
  assign bus.ram_adr     = adr_q;
  assign bus.ram_wdata   = wdata_q;
  assign bus.cpu_reset_n = cpu_q;
  assign bus.err         = err_q;
  assign bus.busy        = is_busy(state_q);

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
//   Scoreboard bench for prog_loader: a frame-level reference model queues
//   the RAM writes and cpu_reset_n transitions each byte should cause, and a
//   monitor pops and compares them whenever the DUT presents a write or a
//   cpu_reset_n change. Directed frames cover the listed scenarios, followed
//   by randomized frames.
module tb_prog_loader;

  localparam int CPB    = 4;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int HUNT = 0, LENP = 1, DATAP = 2, CSUMP = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  prog_loader_if bus();

  prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] wr_q[$];
  logic        cpu_q[$];

  int          m_phase;
  int          m_len;
  int          m_written;
  logic [7:0]  m_sum;
  logic        m_err;
  logic        m_cpu;
  logic        last_cpu;

  function automatic void compare(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  function automatic void set_cpu(input logic v);
    if (v !== m_cpu) begin
      cpu_q.push_back(v);
      m_cpu = v;
    end
  endfunction

  function automatic void model_reset();
    m_phase = HUNT; m_len = 0; m_written = 0; m_sum = 8'h00;
    m_err = 1'b0; m_cpu = 1'b0;
    wr_q.delete(); cpu_q.delete();
  endfunction

  // Frame-level view: hunt for sync, then length, data, checksum.
  function automatic void model_byte(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) begin
      m_err = 1'b1;
      m_phase = HUNT;
      return;
    end
    case (m_phase)
      HUNT: if (b == 8'hA5) begin
        m_err = 1'b0; set_cpu(1'b0); m_phase = LENP;
      end
      LENP: if (b >= 1 && int'(b) <= DEPTH) begin
        m_len = int'(b); m_written = 0; m_sum = 8'h00; m_phase = DATAP;
      end else begin
        m_err = 1'b1; m_phase = HUNT;
      end
      DATAP: begin
        wr_q.push_back({8'(m_written), b});
        m_sum = m_sum + b;
        m_written++;
        if (m_written == m_len) m_phase = CSUMP;
      end
      default: begin
        if (b == m_sum) set_cpu(1'b1);
        else m_err = 1'b1;
        m_phase = HUNT;
      end
    endcase
  endfunction

  task automatic drive_byte(input logic [7:0] b, input bit stop_ok);
    @(negedge clk);
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.rx = stop_ok;
    repeat (CPB) @(negedge clk);
    bus.rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit stop_ok);
    model_byte(b, stop_ok);
    drive_byte(b, stop_ok);
  endtask

  task automatic send_frame(input logic [7:0] bs[$]);
    foreach (bs[i]) applyStimulus(bs[i], 1'b1);
  endtask

  task automatic checkOutput(input string tag);
    repeat (4 * CPB) @(negedge clk);
    compare({tag, "_err"},  16'(bus.err),         16'(m_err));
    compare({tag, "_busy"}, 16'(bus.busy),        16'(m_phase != HUNT));
    compare({tag, "_cpu"},  16'(bus.cpu_reset_n), 16'(m_cpu));
    compare({tag, "_pending_writes"}, 16'(wr_q.size()), 16'd0);
    compare({tag, "_pending_cpu"},    16'(cpu_q.size()), 16'd0);
  endtask

  task automatic check_reset_values(input string tag);
    compare({tag, "_ram_we"},    16'(bus.ram_we),      16'd0);
    compare({tag, "_ram_adr"},   16'(bus.ram_adr),     16'd0);
    compare({tag, "_ram_wdata"}, 16'(bus.ram_wdata),   16'd0);
    compare({tag, "_cpu"},       16'(bus.cpu_reset_n), 16'd0);
    compare({tag, "_busy"},      16'(bus.busy),        16'd0);
    compare({tag, "_err"},       16'(bus.err),         16'd0);
  endtask

  task automatic applyReset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check_reset_values(tag);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Monitor: every write strobe and every cpu_reset_n edge must match the
  // next entry the model queued.
  always @(negedge clk) begin
    if (reset) begin
      last_cpu = bus.cpu_reset_n;
    end else begin
      if (bus.ram_we === 1'b1) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_write actual=%h expected=none", {bus.ram_adr, bus.ram_wdata});
        end else begin
          compare("ram_write", {bus.ram_adr, bus.ram_wdata}, wr_q.pop_front());
        end
      end
      if (bus.cpu_reset_n !== last_cpu) begin
        if (cpu_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_cpu_edge actual=%b expected=none", bus.cpu_reset_n);
        end else begin
          compare("cpu_edge", 16'(bus.cpu_reset_n), 16'(cpu_q.pop_front()));
        end
      end
      last_cpu = bus.cpu_reset_n;
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] fr[$];
    logic [7:0] s;
    int kind, len;

    reset = 1'b0;
    bus.rx = 1'b1;
    last_cpu = 1'b0;
    model_reset();
    #2 reset = 1'b1;
    #1 check_reset_values("por");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] case 1: good frame");
    send_frame('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66});
    checkOutput("case1");

    $display("[TB] case 2: bad checksum");
    send_frame('{8'hA5, 8'h02, 8'h01, 8'h02, 8'h00});
    checkOutput("case2");

    $display("[TB] case 3: bad lengths then good frame");
    send_frame('{8'hA5, 8'h00});
    checkOutput("case3_len0");
    send_frame('{8'hA5, 8'h11});
    checkOutput("case3_len17");
    send_frame('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66});
    checkOutput("case3_good");

    $display("[TB] case 4: framing error mid-data and rx glitch");
    send_frame('{8'hA5, 8'h05, 8'h01, 8'h02});
    applyStimulus(8'h03, 1'b0);
    @(negedge clk) bus.rx = 1'b0;
    @(negedge clk) bus.rx = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    send_frame('{8'h04, 8'h05});
    checkOutput("case4");

    $display("[TB] case 5: reset mid-frame");
    send_frame('{8'hA5, 8'h03, 8'h11, 8'h22});
    repeat (4 * CPB) @(negedge clk);
    compare("case5_pre_writes", 16'(wr_q.size()), 16'd0);
    applyReset("case5");
    send_frame('{8'h33, 8'h66});
    checkOutput("case5_after");

    $display("[TB] case 6: reload from RUN");
    send_frame('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66});
    checkOutput("case6_run");
    send_frame('{8'hA5, 8'h01, 8'h7F, 8'h7F});
    checkOutput("case6_reload");

    $display("[TB] randomized frames");
    for (int n = 0; n < 25; n++) begin
      kind = $urandom_range(0, 9);
      fr.delete();
      if (kind <= 6 || kind == 9) begin
        len = $urandom_range(1, DEPTH);
        s = 8'h00;
        fr.push_back(8'hA5);
        fr.push_back(8'(len));
        for (int i = 0; i < len; i++) begin
          fr.push_back(8'($urandom_range(0, 255)));
          s = s + fr[fr.size() - 1];
        end
        if (kind == 6) s = s + 8'($urandom_range(1, 255));
        if (kind == 9) begin
          len = $urandom_range(2, fr.size() - 1);
          for (int i = 0; i < len; i++) applyStimulus(fr[i], 1'b1);
          applyStimulus(8'($urandom_range(0, 255)), 1'b0);
          fr.delete();
        end else begin
          fr.push_back(s);
        end
      end else if (kind == 7) begin
        fr.push_back(8'hA5);
        fr.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(DEPTH + 1, 255)));
      end else begin
        fr.push_back(8'($urandom_range(0, 255)));
      end
      send_frame(fr);
      checkOutput("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
